// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
//   Successive-approximation controller for the mixed-signal test circuit. It
//   drives a trial code into the DAC, waits a programmable settle time, samples
//   the analog comparator once per bit and resolves the code MSB first. The
//   finished code is returned on result with a one-cycle result_valid strobe.
//
// Parameters
//   WIDTH          conversion resolution in bits (>= 2)
//   SETTLE_CYCLES  clocks waited after each DAC update before sampling (>= 1)
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   begin a conversion (honoured only in IDLE, without abort)
//   cont          in   continuous mode, sampled only in DONE
//   abort         in   synchronous abort of a conversion in progress
//   cmp_in        in   comparator, 1 = analog input >= DAC output
//   track         out  1 = sample/hold tracking, 0 = holding
//   dac_code      out  trial code to the DAC
//   busy          out  1 while settling or deciding
//   result        out  last completed conversion
//   result_valid  out  one-cycle pulse, coincident with a result update
// -----------------------------------------------------------------------------
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             track,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [WIDTH-1:0] MSB_CODE   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dac_code_q, dac_code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             track_q, track_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= IDX_MSB;
            cnt_q          <= '0;
            dac_code_q     <= '0;
            result_q       <= '0;
            track_q        <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            dac_code_q     <= dac_code_d;
            result_q       <= result_d;
            track_q        <= track_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        dac_code_d     = dac_code_q;
        result_d       = result_q;
        track_d        = track_q;
        busy_d         = busy_q;
        result_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A start that coincides with abort is dropped.
                if (start && !abort) begin
                    state_d    = S_SETTLE;
                    dac_code_d = MSB_CODE;
                    idx_d      = IDX_MSB;
                    cnt_d      = CNT_RELOAD;
                    track_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    dac_code_d = '0;
                    track_d    = 1'b1;
                    busy_d     = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_DECIDE: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    dac_code_d = '0;
                    track_d    = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    // Keep the trial bit only if the input is at or above it.
                    dac_code_d[idx_q] = cmp_in;
                    if (idx_q != '0) begin
                        dac_code_d[idx_q - IDX_ONE] = 1'b1;
                        idx_d   = idx_q - IDX_ONE;
                        cnt_d   = CNT_RELOAD;
                        state_d = S_SETTLE;
                    end else begin
                        result_d       = dac_code_d;
                        result_valid_d = 1'b1;
                        busy_d         = 1'b0;
                        state_d        = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (cont && !abort) begin
                    // Back-to-back conversion: the hold is never released.
                    state_d    = S_SETTLE;
                    dac_code_d = MSB_CODE;
                    idx_d      = IDX_MSB;
                    cnt_d      = CNT_RELOAD;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                    dac_code_d = '0;
                    track_d    = 1'b1;
                    busy_d     = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign track        = track_q;
    assign dac_code     = dac_code_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_adc_ctrl
//   Self-checking bench for sar_adc_ctrl. An ideal comparator closes the loop
//   (cmp_in = vin >= dac_code). Expected trial codes and results come from a
//   plain binary-search model; timing expectations come from the conversion
//   latency WIDTH*(SETTLE_CYCLES+1).
// -----------------------------------------------------------------------------
module tb_sar_adc_ctrl;

    localparam int W   = 8;
    localparam int S   = 4;
    localparam int LAT = W * (S + 1);

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cont;
    logic         abort;
    logic         cmp_in;
    logic         track;
    logic [W-1:0] dac_code;
    logic         busy;
    logic [W-1:0] result;
    logic         result_valid;
    logic [W-1:0] vin;

    int total = 0;
    int bad   = 0;

    // Observations from the most recent run_conv call.
    logic [W-1:0] obs_trial [W];
    int           obs_rv_cnt;
    int           obs_rv_edge;
    int           obs_ctl_bad;
    logic [W-1:0] obs_res;
    logic [W-1:0] obs_done_dac;
    bit           track_seen_hi;

    typedef struct {
        logic [W-1:0] vin;
        logic [W-1:0] exp_res;
    } vec_t;

    vec_t tbl [6];

    sar_adc_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cont         (cont),
        .abort        (abort),
        .cmp_in       (cmp_in),
        .track        (track),
        .dac_code     (dac_code),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    assign cmp_in = (vin >= dac_code);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Binary search: trial k (0 = MSB) is the code resolved so far plus the next bit.
    function automatic logic [W-1:0] model_trial(input logic [W-1:0] v, input int k);
        int code = 0;
        for (int b = W - 1; b > W - 1 - k; b--)
            if (int'(v) >= code + (1 << b)) code += (1 << b);
        return W'(code + (1 << (W - 1 - k)));
    endfunction

    function automatic logic [W-1:0] model_result(input logic [W-1:0] v);
        int code = 0;
        for (int b = W - 1; b >= 0; b--)
            if (int'(v) >= code + (1 << b)) code += (1 << b);
        return W'(code);
    endfunction

    // Runs one conversion from IDLE with cont=0. start is sampled on edge 0;
    // restart_e / abort_e (-1 = none) pulse start / abort on that edge.
    task automatic run_conv(input logic [W-1:0] v, input int restart_e, input int abort_e);
        bit aborted;
        vin         = v;
        obs_rv_cnt  = 0;
        obs_rv_edge = -1;
        obs_ctl_bad = 0;
        obs_res     = '0;
        for (int e = 0; e <= LAT + 1; e++) begin
            start = (e == 0) || (e == restart_e);
            abort = (e == abort_e);
            tick();
            start = 1'b0;
            abort = 1'b0;
            aborted = (abort_e >= 0) && (e >= abort_e);
            if (result_valid) begin
                obs_rv_cnt++;
                if (obs_rv_edge < 0) obs_rv_edge = e;
                obs_res = result;
            end
            if (aborted) begin
                if (busy !== 1'b0 || track !== 1'b1 || dac_code !== '0) obs_ctl_bad++;
            end else begin
                if (busy !== (e < LAT)) obs_ctl_bad++;
                if (track !== (e > LAT)) obs_ctl_bad++;
            end
            if ((e % (S + 1)) == S && e < LAT) obs_trial[e / (S + 1)] = dac_code;
            if (e == LAT) obs_done_dac = dac_code;
        end
    endtask

    task automatic verify_conv(input string tag, input logic [W-1:0] v, input logic [W-1:0] exp_res);
        for (int k = 0; k < W; k++)
            check($sformatf("%s trial%0d", tag, k), obs_trial[k], model_trial(v, k));
        check({tag, " rv_edge"}, obs_rv_edge, LAT);
        check({tag, " rv_count"}, obs_rv_cnt, 1);
        check({tag, " result"}, obs_res, exp_res);
        check({tag, " done_dac"}, obs_done_dac, exp_res);
        check({tag, " ctl_errs"}, obs_ctl_bad, 0);
        check({tag, " idle_track"}, track, 1);
        check({tag, " idle_dac"}, dac_code, 0);
    endtask

    // Ticks until result_valid is seen or the budget runs out; reports ticks used.
    task automatic wait_rv(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            tick();
            cycles++;
            if (track) track_seen_hi = 1'b1;
            if (result_valid) return;
        end
        cycles = -1;
    endtask

    initial begin
        logic [W-1:0] rv;
        logic [W-1:0] prev_res;
        int n1, n2;

        tbl[0] = '{vin: 8'hA5, exp_res: 8'hA5};
        tbl[1] = '{vin: 8'h00, exp_res: 8'h00};
        tbl[2] = '{vin: 8'hFF, exp_res: 8'hFF};
        tbl[3] = '{vin: 8'h01, exp_res: 8'h01};
        tbl[4] = '{vin: 8'h80, exp_res: 8'h80};
        tbl[5] = '{vin: 8'h7F, exp_res: 8'h7F};

        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        abort = 1'b0;
        vin   = 8'h00;
        #12;
        check("rst track", track, 1);
        check("rst dac", dac_code, 0);
        check("rst busy", busy, 0);
        check("rst result", result, 0);
        check("rst rv", result_valid, 0);
        rst_n = 1'b1;
        tick();

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", busy, 0);
        check("start+abort track", track, 1);
        tick();
        check("start+abort stays idle", busy, 0);

        // table-driven fixed codes, including both boundary codes
        foreach (tbl[i]) begin
            run_conv(tbl[i].vin, -1, -1);
            verify_conv($sformatf("tbl%0d", i), tbl[i].vin, tbl[i].exp_res);
        end

        // random codes against the search model
        for (int i = 0; i < 12; i++) begin
            rv = W'($urandom_range(0, (1 << W) - 1));
            run_conv(rv, -1, -1);
            verify_conv($sformatf("rnd%0d", i), rv, model_result(rv));
        end

        // second start pulse mid-conversion is ignored
        run_conv(8'h96, 10, -1);
        verify_conv("restart", 8'h96, 8'h96);

        // abort at edge 20: back to idle, no strobe, previous result kept
        prev_res = result;
        run_conv(8'h42, -1, 20);
        check("abort rv_count", obs_rv_cnt, 0);
        check("abort ctl_errs", obs_ctl_bad, 0);
        check("abort result kept", result, prev_res);

        // continuous mode, back-to-back conversions
        track_seen_hi = 1'b0;
        vin   = 8'h3C;
        cont  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_rv(3 * LAT, n1);
        check("cont first latency", n1, LAT);
        check("cont first result", result, model_result(8'h3C));
        vin = 8'h3D;
        wait_rv(3 * LAT, n2);
        check("cont spacing", n2, LAT + 1);
        check("cont second result", result, model_result(8'h3D));
        check("cont track stayed low", track_seen_hi, 0);
        cont = 1'b0;
        tick();
        check("cont exit track", track, 1);
        check("cont exit dac", dac_code, 0);
        check("cont exit rv", result_valid, 0);

        // asynchronous reset mid-conversion, between clock edges
        vin   = 8'h33;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst track", track, 1);
        check("arst dac", dac_code, 0);
        check("arst busy", busy, 0);
        check("arst result", result, 0);
        check("arst rv", result_valid, 0);
        #2 rst_n = 1'b1;
        tick();
        check("post-rst idle", busy, 0);
        run_conv(8'h5A, -1, -1);
        verify_conv("post-rst", 8'h5A, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
